dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder (bus slave) for the dbus channel driven by the load/store unit.
- Accepts one request at a time with its address, write data and byte selects.
- Adds a configurable number of wait states, then performs a byte-lane-masked write or a full-word read on an internal word array.
- Returns a single-cycle ready strobe with read data or an error flag; the LSU holds its request until ready.

Parameters:
- DEPTH_LOG2, 12, log2 of array depth in 32-bit words (4096 words = 16 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be 4-byte aligned.
- WAIT_CYC, 2, wait states between request sample and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dbus_req_i  in  1  request valid; held by the LSU until dbus_ready_o.
- dbus_we_i  in  1  1 = store, 0 = load.
- dbus_addr_i  in  32  byte address.
- dbus_data_i  in  32  store data, already shifted into the byte lanes.
- dbus_sel_i  in  4  byte-lane enables.
- dbus_data_o  out  32  read data (full word, unmasked).
- dbus_ready_o  out  1  one-cycle response strobe.
- dbus_err_o  out  1  error; valid only while dbus_ready_o is high.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert): state=IDLE, wait counter=0, all outputs 0, latched request regs 0. Array contents are not reset.
- States: IDLE, WAIT, RESP.
  - IDLE: on a clock edge with dbus_req_i=1, latch we/addr/data/sel, set cnt=WAIT_CYC, go to WAIT. If WAIT_CYC=0, go directly to RESP.
  - WAIT: cnt decrements each edge; when cnt==1, next state is RESP. Live inputs are ignored.
  - RESP: lasts one cycle; dbus_ready_o=1; next state is IDLE unconditionally. dbus_req_i seen in this cycle belongs to the finishing access and is ignored.
- Latency: request sampled at edge N gives dbus_ready_o high during cycle N+1+WAIT_CYC. Throughput is one access per WAIT_CYC+2 cycles.
- Legality check on the latched request (all three must hold):
  - address in [BASE_ADDR, BASE_ADDR + 4·2^DEPTH_LOG2);
  - sel is one of 0001/0010/0100/1000 (lane index == addr[1:0]), 0011 (addr[1:0]=00), 1100 (addr[1:0]=10), or 1111 (addr[1:0]=00);
  - sel != 0000.
- Word index = (addr - BASE_ADDR)[DEPTH_LOG2+1:2].
- Store: on the edge entering RESP, array lanes with sel[i]=1 take dbus_data_i lane i; other lanes are unchanged. dbus_data_o is 0 for store responses.
- Load: dbus_data_o is the full array word, registered on the edge entering RESP. Lane extraction and sign extension are the LSU's job.
- Read-after-write returns the new data.
- Illegal request: no array write; dbus_err_o=1 and dbus_data_o=0 during the RESP cycle.
- dbus_data_o holds its value until the next response; dbus_err_o clears when leaving RESP.
- Reset asserted in WAIT: the access is aborted, no write occurs, and no ready is issued.

Decomposition:
- defines.v: add `DMEM_BASE, `DMEM_DEPTH_LOG2, and 2-bit state encodings `DMEM_IDLE/`DMEM_WAIT/`DMEM_RESP.
- Reuse the existing `MemBus, `InstAddrBus and `ByteSel widths.
- Sub-module dmem_sram_array: synchronous byte-enabled write and combinational read, no reset. Keeps the array swappable for a vendor macro.

Test Plan:
- Reset: assert rst between edges while in WAIT → all outputs 0 immediately; busy_o=0.
- Word round-trip (WAIT_CYC=2): sw addr 0x8000_0010, data 0xDEADBEEF, sel 1111 at edge N → ready at N+3, err=0. Then lw same address → dbus_data_o=0xDEADBEEF.
- Byte and half stores:
  - sb addr 0x8000_0011, data 0x0000AA00, sel 0010, then lw → 0xDEADAAEF.
  - sh addr 0x8000_0012, data 0x12340000, sel 1100, then lw → 0x1234AAEF.
- Errors (each must give err=1 with ready=1, data_o=0, and the following lw of 0x8000_0010 unchanged at 0x1234AAEF):
  - lw 0x7FFF_FFFC (below base);
  - lw 0x8000_4000 (past end);
  - sb addr 0x8000_0010 with sel 0010;
  - sel 0000.
- Aborted write: sw 0x8000_0020 data 0x11111111, pulse rst during WAIT → no ready; after reset, lw 0x8000_0020 returns the prior contents.
- WAIT_CYC=0 instance: back-to-back requests held high → ready every 2nd cycle (N+1, N+3, ...); busy_o toggles 1/0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants, state encoding and lane-legality helper for dmem_responder
package dmem_responder_pkg;

  localparam logic [31:0] DMEM_BASE       = 32'h8000_0000;
  localparam int          DMEM_DEPTH_LOG2 = 12;
  localparam int          MEM_BUS_W       = 32;
  localparam int          BYTE_SEL_W      = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Naturally aligned byte, half or word selects only; an empty select is illegal.
  function automatic logic sel_legal(input logic [BYTE_SEL_W-1:0] sel, input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (sel)
      4'b0001: ok = (lane == 2'd0);
      4'b0010: ok = (lane == 2'd1);
      4'b0100: ok = (lane == 2'd2);
      4'b1000: ok = (lane == 2'd3);
      4'b0011: ok = (lane == 2'd0);
      4'b1100: ok = (lane == 2'd2);
      4'b1111: ok = (lane == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// rtl/dmem_sram_array.sv - byte-enabled synchronous-write, combinational-read word array (no reset)
module dmem_sram_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_SEL_W-1:0] be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [MEM_BUS_W-1:0]  wdata,
  output logic [MEM_BUS_W-1:0]  rdata
);

  logic [MEM_BUS_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTE_SEL_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dbus slave: latches one request, waits WAIT_CYC cycles, then reads or writes the array
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DMEM_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE,
  parameter int          WAIT_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dbus_req_i,
  input  logic                  dbus_we_i,
  input  logic [31:0]           dbus_addr_i,
  input  logic [MEM_BUS_W-1:0]  dbus_data_i,
  input  logic [BYTE_SEL_W-1:0] dbus_sel_i,
  output logic [MEM_BUS_W-1:0]  dbus_data_o,
  output logic                  dbus_ready_o,
  output logic                  dbus_err_o,
  output logic                  busy_o
);

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYC);
  localparam logic [32:0] SPAN      = 33'd1 << (DEPTH_LOG2 + 2);

  dmem_state_e           state, state_nxt;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [MEM_BUS_W-1:0]  wdata_q;
  logic [BYTE_SEL_W-1:0] sel_q;
  logic [MEM_BUS_W-1:0]  rdata_q;
  logic                  err_q;

  logic                  idle;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [MEM_BUS_W-1:0]  acc_wdata;
  logic [BYTE_SEL_W-1:0] acc_sel;
  logic [31:0]           off;
  logic                  legal;
  logic                  enter_resp;
  logic                  mem_we;
  logic [MEM_BUS_W-1:0]  mem_rdata;

  // With WAIT_CYC=0 the access completes on the sampling edge, so the live bus feeds it.
  assign idle      = (state == DMEM_IDLE);
  assign acc_we    = idle ? dbus_we_i   : we_q;
  assign acc_addr  = idle ? dbus_addr_i : addr_q;
  assign acc_wdata = idle ? dbus_data_i : wdata_q;
  assign acc_sel   = idle ? dbus_sel_i  : sel_q;

  // Addresses below the base wrap to large offsets and fail the range compare.
  assign off        = acc_addr - BASE_ADDR;
  assign legal      = ({1'b0, off} < SPAN) && sel_legal(acc_sel, acc_addr[1:0]);
  assign enter_resp = (state_nxt == DMEM_RESP) && (state != DMEM_RESP);
  assign mem_we     = enter_resp && legal && acc_we && !rst;

  dmem_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (acc_sel),
    .addr (off[DEPTH_LOG2+1:2]),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      DMEM_IDLE: if (dbus_req_i) state_nxt = (WAIT_CYC == 0) ? DMEM_RESP : DMEM_WAIT;
      DMEM_WAIT: if (cnt == 4'd1) state_nxt = DMEM_RESP;
      DMEM_RESP: state_nxt = DMEM_IDLE;
      default:   state_nxt = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DMEM_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idle && dbus_req_i) begin
        we_q    <= dbus_we_i;
        addr_q  <= dbus_addr_i;
        wdata_q <= dbus_data_i;
        sel_q   <= dbus_sel_i;
        cnt     <= WAIT_INIT;
      end else if (state == DMEM_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= (legal && !acc_we) ? mem_rdata : '0;
        err_q   <= !legal;
      end else if (state == DMEM_RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  assign dbus_data_o  = rdata_q;
  assign dbus_err_o   = err_q;
  assign dbus_ready_o = (state == DMEM_RESP);
  assign busy_o       = !idle;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_CYC=2 and WAIT_CYC=0 instances)
module tb_dmem_responder;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q1[$];
  exp_t        q0[$];
  exp_t        e1, e0;

  logic        r1_req = 0, r1_we = 0;
  logic [31:0] r1_addr = 0, r1_wdata = 0;
  logic [3:0]  r1_sel = 0;
  logic [31:0] r1_data;
  logic        r1_ready, r1_err, r1_busy;

  logic        r0_req = 0, r0_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0;
  logic [3:0]  r0_sel = 0;
  logic [31:0] r0_data;
  logic        r0_ready, r0_err, r0_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .WAIT_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .dbus_req_i(r1_req), .dbus_we_i(r1_we), .dbus_addr_i(r1_addr),
    .dbus_data_i(r1_wdata), .dbus_sel_i(r1_sel), .dbus_data_o(r1_data),
    .dbus_ready_o(r1_ready), .dbus_err_o(r1_err), .busy_o(r1_busy)
  );

  dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .dbus_req_i(r0_req), .dbus_we_i(r0_we), .dbus_addr_i(r0_addr),
    .dbus_data_i(r0_wdata), .dbus_sel_i(r0_sel), .dbus_data_o(r0_data),
    .dbus_ready_o(r0_ready), .dbus_err_o(r0_err), .busy_o(r0_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, input logic err, input logic [31:0] rdata);
    exp_t e;
    int   n;
    @(negedge clk);
    r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_sel = sel; r1_req = 1'b1;
    e.err = err; e.data = rdata; e.cyc = cyc + 1 + 2;
    q1.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r1_ready && n < 40);
    if (!r1_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout addr=%h actual=no_ready required=ready", addr);
    end
    r1_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && r1_ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL r1_unexpected_ready cyc=%0d actual=ready required=none", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("r1_err", {31'd0, r1_err}, {31'd0, e1.err});
        chk("r1_data", r1_data, e1.data);
        chk("r1_latency_cycle", cyc, e1.cyc);
      end
    end
    if (!rst && r0_ready) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL r0_unexpected_ready cyc=%0d actual=ready required=none", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("r0_err", {31'd0, r0_err}, {31'd0, e0.err});
        chk("r0_data", r0_data, e0.data);
        chk("r0_latency_cycle", cyc, e0.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   c;
    #1;
    chk("reset_ready", {31'd0, r1_ready}, 32'd0);
    chk("reset_err", {31'd0, r1_err}, 32'd0);
    chk("reset_data", r1_data, 32'd0);
    chk("reset_busy", {31'd0, r1_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'hDEAD_BEEF);
    issue(1, 32'h8000_0011, 32'h0000_AA00, 4'b0010, 0, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'hDEAD_AAEF);
    issue(1, 32'h8000_0012, 32'h1234_0000, 4'b1100, 0, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'h1234_AAEF);

    issue(0, 32'h7FFF_FFFC, 32'h0, 4'b1111, 1, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'h1234_AAEF);
    issue(0, 32'h8000_4000, 32'h0, 4'b1111, 1, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'h1234_AAEF);
    issue(1, 32'h8000_0010, 32'h0000_FF00, 4'b0010, 1, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'h1234_AAEF);
    issue(1, 32'h8000_0010, 32'h5555_5555, 4'b0000, 1, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'h1234_AAEF);

    issue(1, 32'h8000_3FFC, 32'h0A0B_0C0D, 4'b1111, 0, 32'h0);
    issue(0, 32'h8000_3FFC, 32'h0, 4'b1111, 0, 32'h0A0B_0C0D);

    issue(1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111, 0, 32'h0);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111, 0, 32'h1234_AAEF);
    @(negedge clk);
    r1_we = 1; r1_addr = 32'h8000_0020; r1_wdata = 32'h1111_1111; r1_sel = 4'b1111; r1_req = 1'b1;
    @(posedge clk);
    #2;
    chk("wait_busy", {31'd0, r1_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, r1_ready}, 32'd0);
    chk("abort_err", {31'd0, r1_err}, 32'd0);
    chk("abort_data", r1_data, 32'd0);
    chk("abort_busy", {31'd0, r1_busy}, 32'd0);
    r1_req = 1'b0;
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(0, 32'h8000_0020, 32'h0, 4'b1111, 0, 32'hCAFE_F00D);

    @(negedge clk);
    r0_we = 1; r0_addr = 32'h8000_0000; r0_wdata = 32'h55AA_55AA; r0_sel = 4'b1111; r0_req = 1'b1;
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      e.err = 0; e.data = 32'h0; e.cyc = c + 1 + 2 * k;
      q0.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_busy", {31'd0, r0_busy}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    r0_we = 0;
    e.err = 0; e.data = 32'h55AA_55AA; e.cyc = cyc + 1;
    q0.push_back(e);
    @(negedge clk);
    r0_req = 1'b0;

    repeat (5) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
